pc_fetch_sequencer: RTL
=======================

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 redirect_valid  input  1  jump unit (jal/jalr/branch) requests a PC change this cycle.
REQ-005 redirect_pc  input  32  new PC from the jump unit's next_pc; sampled when redirect_valid=1.
REQ-006 imem_req_valid  output  1  instruction-memory read request valid.
REQ-007 imem_req_ready  input  1  memory accepts request when valid&ready.
REQ-008 imem_req_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  read data valid; never in the same cycle as acceptance of its request.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 inst_valid  output  1  fetched instruction offered to decode.
REQ-012 inst_ready  input  1  decode accepts instruction when inst_valid&inst_ready.
REQ-013 inst_data  output  32  instruction word held for decode.
REQ-014 inst_pc  output  32  address of inst_data (decode uses it for pc+4 / pc+imm).
REQ-015 fetch_fault  output  1  sticky misaligned-redirect indication.

Function
REQ-016 The block SHALL implement states FETCH, WAIT, HOLD, DRAIN, FAULT, registered in a state register with one PC register.
REQ-017 FETCH: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready=1 SHALL go to WAIT.
REQ-018 WAIT: on imem_rsp_valid=1 SHALL latch inst_data=imem_rsp_data, inst_pc=pc, go to HOLD.
REQ-019 HOLD: inst_valid=1, inst_data/inst_pc SHALL be stable; on inst_ready=1 SHALL set pc=pc+4 (mod 2^32 wrap) and go to FETCH.
REQ-020 inst_valid SHALL be 1 only in HOLD; imem_req_valid only in FETCH.
REQ-021 Minimum latency: request accept to inst_valid = 2 cycles (rsp one cycle after accept, HOLD next cycle).
REQ-022 Redirect with redirect_pc[1:0]==0 SHALL set pc=redirect_pc next cycle in every non-FAULT state and take priority over all other transitions.
REQ-023 Redirect in FETCH without imem_req_ready: stay FETCH, address changes next cycle (sole permitted change of an unaccepted request).
REQ-024 Redirect in FETCH with imem_req_ready=1 same cycle: go to DRAIN (accepted request is stale).
REQ-025 Redirect in WAIT without imem_rsp_valid: go to DRAIN; with imem_rsp_valid same cycle: discard response, go to FETCH.
REQ-026 Redirect in HOLD: drop held instruction, go to FETCH, even if inst_ready=1 same cycle (no handshake counted, no pc+4).
REQ-027 DRAIN: on imem_rsp_valid=1 SHALL discard data and go to FETCH; redirect in DRAIN updates pc, remains DRAIN unless rsp arrives same cycle.
REQ-028 Redirect with redirect_pc[1:0]!=0 SHALL set fetch_fault=1 and enter FAULT; pc unchanged; FAULT drives all valids 0, ignores all inputs, exits only by reset.
REQ-029 Misaligned redirect in WAIT: response still outstanding is ignored in FAULT.
REQ-030 At most one imem request outstanding at any time.

Reset
REQ-031 While reset_n=0: state=FETCH, pc=RESET_PC, inst_data=0, inst_pc=0, fetch_fault=0, inst_valid=0; imem_req_valid SHALL be 0 during reset and rise the first cycle after deassertion.
REQ-032 Reset assertion mid-transaction SHALL abandon any outstanding request; first post-reset response is the memory model's responsibility to suppress.

Verification
REQ-033 Reset release, ready=1, rsp 1 cycle later with 32'h0000_0013, inst_ready=1 -> inst_pc=0, next req addr=4, then 8.
REQ-034 Decode stalls (inst_ready=0 for 5 cycles) -> inst_valid/inst_data/inst_pc stable, no new imem request issued.
REQ-035 Redirect to 32'h0000_0100 in WAIT, rsp 2 cycles later -> response discarded, next request addr=0x100, inst_pc=0x100.
REQ-036 Redirect to 0x200 in HOLD with inst_ready=1 same cycle -> no pc+4, next request addr=0x200.
REQ-037 Redirect to 32'h0000_0102 -> fetch_fault=1, valids 0 until reset_n low; pc=32'hFFFF_FFFC fetch accepted -> next addr 0 (wrap).
REQ-038 reset_n low during WAIT -> outputs return to reset values immediately; first request after release at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: issues one word fetch at a time, holds the returned
// instruction for decode, and follows jump-unit redirects with stale-response draining.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_n;
    logic [31:0] pc_r;
    logic [31:0] pc_n;
    logic        fault_r;
    logic        fault_n;
    logic        req_valid_r;
    logic [31:0] req_addr_r;
    logic        inst_valid_r;
    logic [31:0] inst_data_r;
    logic [31:0] inst_pc_r;
    logic        accept_s;
    logic        latch_s;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    // The request only counts as accepted once the registered valid is actually driven.
    assign accept_s = req_valid_r & imem_req_ready;

    // Next-state and next-pc selection; a redirect outranks every handshake.
    always_comb begin
        state_n = state_r;
        pc_n    = pc_r;
        fault_n = fault_r;
        latch_s = 1'b0;
        if (state_r == FAULT) begin
            state_n = FAULT;
        end else if (redirect_valid) begin
            if (is_misaligned(redirect_pc[1:0])) begin
                fault_n = 1'b1;
                state_n = FAULT;
            end else begin
                pc_n = redirect_pc;
                case (state_r)
                    FETCH:   state_n = accept_s ? DRAIN : FETCH;
                    WAIT:    state_n = imem_rsp_valid ? FETCH : DRAIN;
                    HOLD:    state_n = FETCH;
                    DRAIN:   state_n = imem_rsp_valid ? FETCH : DRAIN;
                    default: begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                    end
                endcase
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (accept_s) begin
                        state_n = WAIT;
                    end else begin
                        state_n = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state_n = HOLD;
                        latch_s = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        state_n = FETCH;
                        pc_n    = pc_r + 32'd4;
                    end else begin
                        state_n = HOLD;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_n = FETCH;
                    end else begin
                        state_n = DRAIN;
                    end
                end
                default: begin
                    state_n = FAULT;
                    fault_n = 1'b1;
                end
            endcase
        end
    end

    // State, pc and registered outputs; valids are decoded from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            fault_r      <= 1'b0;
            req_valid_r  <= 1'b0;
            req_addr_r   <= RESET_PC;
            inst_valid_r <= 1'b0;
            inst_data_r  <= 32'h0000_0000;
            inst_pc_r    <= 32'h0000_0000;
        end else begin
            state_r      <= state_n;
            pc_r         <= pc_n;
            fault_r      <= fault_n;
            req_valid_r  <= (state_n == FETCH);
            req_addr_r   <= pc_n;
            inst_valid_r <= (state_n == HOLD);
            if (latch_s) begin
                inst_data_r <= imem_rsp_data;
                inst_pc_r   <= pc_r;
            end else begin
                inst_data_r <= inst_data_r;
                inst_pc_r   <= inst_pc_r;
            end
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = req_addr_r;
    assign inst_valid     = inst_valid_r;
    assign inst_data      = inst_data_r;
    assign inst_pc        = inst_pc_r;
    assign fetch_fault    = fault_r;

endmodule

// Protocol invariants of the fetch sequencer outputs.
module pc_fetch_sequencer_checker (
    input logic       clock,
    input logic       reset_n,
    input logic       imem_req_valid,
    input logic [1:0] imem_req_addr_low,
    input logic       inst_valid,
    input logic       fetch_fault
);

    a_single_valid: assert property (@(posedge clock) disable iff (!reset_n)
        !(imem_req_valid && inst_valid));

    a_fault_quiet: assert property (@(posedge clock) disable iff (!reset_n)
        fetch_fault |-> (!imem_req_valid && !inst_valid));

    a_aligned: assert property (@(posedge clock) disable iff (!reset_n)
        imem_req_valid |-> (imem_req_addr_low == 2'b00));

endmodule
